// File: rtl/dac_spi_tx.sv
`default_nettype none
// ============================================================================
// Module      : dac_spi_tx
// Description : SPI transmitter for a 12-bit DAC; sends {CMD, din} MSB first
//               with SETUP / SHIFT / HOLD / GAP framing around each word.
// Revision    : 1.0 - initial release
// ============================================================================
module dac_spi_tx #(
    parameter int         CLK_DIV = 2,
    parameter logic [3:0] CMD     = 4'b0011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enb,
    input  logic [11:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic        sclk,
    output logic        mosi,
    output logic        cs_n,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_setup = 3'd1;
    localparam logic [2:0] c_st_shift = 3'd2;
    localparam logic [2:0] c_st_hold  = 3'd3;
    localparam logic [2:0] c_st_gap   = 3'd4;
    localparam logic [7:0] c_last     = 8'(CLK_DIV - 1);

    logic [2:0]  r_state;
    logic [7:0]  r_cnt;
    logic [3:0]  r_bit;
    logic        r_phase;
    logic [15:0] r_shreg;
    logic        r_sclk;
    logic        r_mosi;
    logic        r_cs_n;
    logic        r_done;

    logic [2:0]  w_state_nxt;
    logic [7:0]  w_cnt_nxt;
    logic [3:0]  w_bit_nxt;
    logic        w_phase_nxt;
    logic        w_next_bit;
    logic        w_accept;
    logic        w_last;
    logic        w_frame_active;
    logic [15:0] w_shreg_nxt;
    logic        w_sclk_nxt;
    logic        w_mosi_nxt;
    logic        w_cs_n_nxt;
    logic        w_done_nxt;

    // Ready drops combinationally during reset so nothing is accepted on a reset edge
    assign din_ready = enb & ~rst & (r_state == c_st_idle);
    assign busy      = (r_state != c_st_idle);
    assign w_accept  = din_valid & din_ready;
    assign w_last    = (r_cnt == c_last);

    assign sclk = r_sclk;
    assign mosi = r_mosi;
    assign cs_n = r_cs_n;
    assign done = r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_phase <= 1'b0;
            r_shreg <= '0;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
            r_cs_n  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_phase <= w_phase_nxt;
            r_shreg <= w_shreg_nxt;
            r_sclk  <= w_sclk_nxt;
            r_mosi  <= w_mosi_nxt;
            r_cs_n  <= w_cs_n_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 8'd1;
        w_bit_nxt   = r_bit;
        w_phase_nxt = r_phase;
        w_next_bit  = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_cnt_nxt   = '0;
                w_bit_nxt   = '0;
                w_phase_nxt = 1'b0;
                if (w_accept) w_state_nxt = c_st_setup;
            end
            c_st_setup: begin
                if (w_last) begin
                    w_state_nxt = c_st_shift;
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_phase_nxt = 1'b0;
                end
            end
            c_st_shift: begin
                if (w_last) begin
                    w_cnt_nxt = '0;
                    if (!r_phase) begin
                        w_phase_nxt = 1'b1;
                    end else if (r_bit == 4'd15) begin
                        w_state_nxt = c_st_hold;
                    end else begin
                        w_bit_nxt   = r_bit + 4'd1;
                        w_phase_nxt = 1'b0;
                        w_next_bit  = 1'b1;
                    end
                end
            end
            c_st_hold: begin
                if (w_last) begin
                    w_state_nxt = c_st_gap;
                    w_cnt_nxt   = '0;
                end
            end
            c_st_gap: begin
                if (w_last) begin
                    w_state_nxt = c_st_idle;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_cnt_nxt   = '0;
            end
        endcase
        if (!enb) begin
            w_state_nxt = c_st_idle;
            w_cnt_nxt   = '0;
            w_bit_nxt   = '0;
            w_phase_nxt = 1'b0;
            w_next_bit  = 1'b0;
        end
    end

    // Outputs are computed from the next state so they register in step with it
    always_comb begin
        w_frame_active = (w_state_nxt == c_st_setup) | (w_state_nxt == c_st_shift) |
                         (w_state_nxt == c_st_hold);
        w_shreg_nxt = r_shreg;
        if (w_accept)
            w_shreg_nxt = {CMD, din};
        else if (w_next_bit)
            w_shreg_nxt = {r_shreg[14:0], 1'b0};
        else if (w_state_nxt == c_st_idle)
            w_shreg_nxt = '0;
        w_cs_n_nxt = ~w_frame_active;
        w_sclk_nxt = (w_state_nxt == c_st_shift) & w_phase_nxt;
        w_mosi_nxt = w_frame_active & w_shreg_nxt[15];
        w_done_nxt = (w_state_nxt == c_st_gap) & (w_cnt_nxt == c_last);
    end

endmodule
`default_nettype wire

// File: tb/tb_dac_spi_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_dac_spi_tx
// Description : Bench for dac_spi_tx; two instances (CLK_DIV=2 and 1) share
//               stimulus and are compared every cycle against a frame model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_spi_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        enb;
    logic        din_valid;
    logic [11:0] din;
    logic        din_ready0, sclk0, mosi0, cs_n0, busy0, done0;
    logic        din_ready1, sclk1, mosi1, cs_n1, busy1, done1;

    dac_spi_tx #(.CLK_DIV(2), .CMD(4'b0011)) u_dut0 (
        .clk(clk), .rst(rst), .enb(enb), .din(din), .din_valid(din_valid),
        .din_ready(din_ready0), .sclk(sclk0), .mosi(mosi0), .cs_n(cs_n0),
        .busy(busy0), .done(done0)
    );

    dac_spi_tx #(.CLK_DIV(1), .CMD(4'b0011)) u_dut1 (
        .clk(clk), .rst(rst), .enb(enb), .din(din), .din_valid(din_valid),
        .din_ready(din_ready1), .sclk(sclk1), .mosi(mosi1), .cs_n(cs_n1),
        .busy(busy1), .done(done1)
    );

    always #8 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int div_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    // Expected outputs for cycle t (1-based) after accept:
    // returns {mosi_meaningful, cs_n, sclk, mosi, done, busy}
    function automatic logic [5:0] model_out(input int d, input bit act, input int t,
                                             input logic [15:0] f);
        logic cs, sc, mo, dn, mv;
        int   s, k;
        cs = 1'b1; sc = 1'b0; mo = 1'b0; dn = 1'b0; mv = 1'b1;
        if (act) begin
            if (t <= d) begin
                cs = 1'b0; mo = f[15];
            end else if (t <= 33 * d) begin
                s  = t - d - 1;
                k  = s / (2 * d);
                cs = 1'b0;
                sc = ((s % (2 * d)) >= d);
                mo = f[15 - k];
            end else if (t <= 34 * d) begin
                cs = 1'b0; mv = 1'b0;
            end else begin
                mv = 1'b0; dn = (t == 35 * d);
            end
        end
        return {mv, cs, sc, mo, dn, act};
    endfunction

    bit          m_act [2];
    int          m_t   [2];
    logic [15:0] m_f   [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst || !enb) begin
                m_act[i] <= 1'b0;
            end else if (m_act[i]) begin
                if (m_t[i] == 35 * div_of(i)) m_act[i] <= 1'b0;
                else                          m_t[i]   <= m_t[i] + 1;
            end else if (din_valid) begin
                m_act[i] <= 1'b1;
                m_t[i]   <= 1;
                m_f[i]   <= {4'b0011, din};
            end
        end
    end

    int          mon_cyc[2], mon_edges[2], mon_cslow[2], mon_since_done[2];
    int          mon_hrun[2], last_hrun[2], acc_gap[2];
    int          done_cnt[2], done_lat[2], done_edges[2], done_cslow[2];
    logic [15:0] mon_word[2];
    logic [31:0] done_word[2];
    bit          prev_sclk[2], acc_seen[2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [5:0] e;
            logic cs, sc, mo, dn, bz, rd;
            cs = (i == 0) ? cs_n0 : cs_n1;
            sc = (i == 0) ? sclk0 : sclk1;
            mo = (i == 0) ? mosi0 : mosi1;
            dn = (i == 0) ? done0 : done1;
            bz = (i == 0) ? busy0 : busy1;
            rd = (i == 0) ? din_ready0 : din_ready1;
            e  = model_out(div_of(i), m_act[i], m_t[i], m_f[i]);
            chk1($sformatf("dut%0d cs_n", i), cs, e[4]);
            chk1($sformatf("dut%0d sclk", i), sc, e[3]);
            if (e[5]) chk1($sformatf("dut%0d mosi", i), mo, e[2]);
            chk1($sformatf("dut%0d done", i), dn, e[1]);
            chk1($sformatf("dut%0d busy", i), bz, e[0]);
            chk1($sformatf("dut%0d din_ready", i), rd, enb && !rst && !m_act[i]);

            if (acc_seen[i]) begin
                mon_cyc[i] = 1; mon_word[i] = '0; mon_edges[i] = 0; mon_cslow[i] = 0;
            end else begin
                mon_cyc[i]++;
            end
            mon_since_done[i]++;
            if (sc && !prev_sclk[i]) begin
                mon_word[i] = {mon_word[i][14:0], mo};
                mon_edges[i]++;
            end
            if (!cs) begin
                mon_cslow[i]++;
                if (mon_hrun[i] > 0) last_hrun[i] = mon_hrun[i];
                mon_hrun[i] = 0;
            end else begin
                mon_hrun[i]++;
            end
            if (dn) begin
                done_cnt[i]++;
                done_lat[i]       = mon_cyc[i];
                done_word[i]      = {16'h0, mon_word[i]};
                done_edges[i]     = mon_edges[i];
                done_cslow[i]     = mon_cslow[i];
                mon_since_done[i] = 0;
            end
            prev_sclk[i] = sc;
            acc_seen[i]  = rd && din_valid;
            if (acc_seen[i]) acc_gap[i] = mon_since_done[i];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [11:0] v, input bit scramble);
        int b0, b1;
        b0 = done_cnt[0];
        b1 = done_cnt[1];
        din = v; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        for (int k = 0; k < 200 && (done_cnt[0] == b0 || done_cnt[1] == b1); k++) begin
            if (scramble) din = 12'($urandom);
            step();
        end
        chk1("frame completes in time", (done_cnt[0] != b0) && (done_cnt[1] != b1), 1'b1);
    endtask

    task automatic wait_edges(input int n);
        for (int k = 0; k < 200 && mon_edges[0] != n; k++) step();
        chk1("sclk edge wait", mon_edges[0] == n, 1'b1);
    endtask

    initial begin
        #(16 * 100000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b0;
        rst = 1'b1; enb = 1'b0; din = '0; din_valid = 1'b0;
        repeat (3) step();
        enb = 1'b1;
        repeat (2) step();
        chk1("reset cs_n", cs_n0, 1'b1);
        chk1("reset sclk", sclk0, 1'b0);
        chk1("reset mosi", mosi0, 1'b0);
        chk1("reset done", done0, 1'b0);
        chk1("reset busy", busy0, 1'b0);
        chk1("ready held low in reset", din_ready0, 1'b0);
        rst = 1'b0;
        #1;
        chk1("ready after reset", din_ready0, 1'b1);
        repeat (2) step();

        // Single frame; din scrambled while the frame is in flight
        run_frame(12'hABC, 1'b1);
        chkw("abc word div2", done_word[0], 32'h3ABC);
        chkw("abc cs low div2", done_cslow[0], 68);
        chkw("abc done latency div2", done_lat[0], 70);
        chkw("abc sclk edges div2", done_edges[0], 16);
        chkw("abc word div1", done_word[1], 32'h3ABC);
        chkw("abc done latency div1", done_lat[1], 35);
        repeat (3) step();

        run_frame(12'h001, 1'b1);
        chkw("001 word div1", done_word[1], 32'h3001);
        chkw("001 done latency div1", done_lat[1], 35);
        chkw("001 cs low div1", done_cslow[1], 34);
        chkw("001 sclk edges div1", done_edges[1], 16);
        chkw("001 word div2", done_word[0], 32'h3001);
        repeat (3) step();

        // Back-to-back frames with din_valid held
        b0 = done_cnt[0];
        din = 12'hFFF; din_valid = 1'b1;
        for (int k = 0; k < 10 && !acc_seen[0]; k++) step();
        chk1("b2b first accept", acc_seen[0], 1'b1);
        din = 12'h000;
        for (int k = 0; k < 200 && done_cnt[0] == b0; k++) step();
        chkw("b2b first word", done_word[0], 32'h3FFF);
        for (int k = 0; k < 10 && !acc_seen[0]; k++) step();
        chk1("b2b second accept", acc_seen[0], 1'b1);
        chkw("b2b accept after done", acc_gap[0], 1);
        din_valid = 1'b0;
        b0 = done_cnt[0];
        for (int k = 0; k < 200 && done_cnt[0] == b0; k++) step();
        chkw("b2b second word", done_word[0], 32'h3000);
        chkw("b2b cs_n high gap", last_hrun[0], 3);
        repeat (3) step();

        // Enable dropped mid-frame
        b0 = done_cnt[0];
        din = 12'h7E5; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        wait_edges(5);
        enb = 1'b0;
        step();
        chk1("enb drop cs_n", cs_n0, 1'b1);
        chk1("enb drop sclk", sclk0, 1'b0);
        chk1("enb drop mosi", mosi0, 1'b0);
        chk1("enb drop busy", busy0, 1'b0);
        chk1("enb drop ready", din_ready0, 1'b0);
        repeat (80) step();
        chkw("enb drop no done", done_cnt[0], b0);
        enb = 1'b1;
        step();
        run_frame(12'h50A, 1'b0);
        chkw("re-enable word div2", done_word[0], 32'h350A);
        chkw("re-enable word div1", done_word[1], 32'h350A);
        repeat (3) step();

        // Reset pulse in the middle of SHIFT
        din = 12'h9C3; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        wait_edges(3);
        rst = 1'b1;
        step();
        chk1("mid reset cs_n", cs_n0, 1'b1);
        chk1("mid reset sclk", sclk0, 1'b0);
        chk1("mid reset mosi", mosi0, 1'b0);
        chk1("mid reset busy", busy0, 1'b0);
        chk1("mid reset ready", din_ready0, 1'b0);
        rst = 1'b0;
        #1;
        chk1("ready after mid reset", din_ready0, 1'b1);
        repeat (3) step();

        // Randomized traffic, checked cycle by cycle against the model
        for (int k = 0; k < 4000; k++) begin
            din       = 12'($urandom);
            din_valid = ($urandom_range(0, 3) != 0);
            enb       = ($urandom_range(0, 59) != 0);
            rst       = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0; enb = 1'b1; din_valid = 1'b0;
        repeat (100) step();

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dac_spi_tx.md
DAC_SPI_TX -- requirements
Module: dac_spi_tx

Interface
REQ-001 Parameter CLK_DIV, default 2, meaning clk cycles per SCLK half-period; legal range 1..255.
REQ-002 Parameter CMD, default 4'b0011, meaning 4-bit DAC command prefixed to every frame.
REQ-003 Port clk, input, 1, meaning single 16 ns master clock; all logic on posedge clk.
REQ-004 Port rst, input, 1, meaning synchronous active-high reset.
REQ-005 Port enb, input, 1, meaning active-high enable.
REQ-006 Port din, input, 12, meaning sample to transmit; this is the ramp/pattern generator output.
REQ-007 Port din_valid, input, 1, meaning din holds a sample to send.
REQ-008 Port din_ready, output, 1, meaning block accepts din this cycle.
REQ-009 Port sclk, output, 1, meaning SPI serial clock, idle low.
REQ-010 Port mosi, output, 1, meaning SPI data, MSB first.
REQ-011 Port cs_n, output, 1, meaning DAC chip select, active low.
REQ-012 Port busy, output, 1, meaning a frame is in progress (state != IDLE).
REQ-013 Port done, output, 1, meaning one-cycle pulse at frame completion.

Function
REQ-014 Frame SHALL be 16 bits {CMD, din}, latched into a shift register on accept; din changes after accept have no effect.
REQ-015 Accept SHALL occur on a cycle with din_valid=1 and din_ready=1; din_ready SHALL equal enb AND state==IDLE (combinational); no buffering beyond the shift register.
REQ-016 FSM states SHALL be IDLE, SETUP, SHIFT, HOLD, GAP; all outputs registered except din_ready and busy.
REQ-017 IDLE: cs_n=1, sclk=0, mosi=0; on accept, go to SETUP next cycle.
REQ-018 SETUP: cs_n=0, sclk=0, mosi=frame bit 15, for CLK_DIV cycles, then SHIFT.
REQ-019 SHIFT: per bit, sclk=0 for CLK_DIV cycles, then sclk=1 for CLK_DIV cycles; mosi SHALL update only at the start of each low phase and hold stable through the high phase; 16 bits, MSB first.
REQ-020 After the 16th high phase: HOLD, with cs_n=0 and sclk=0 for CLK_DIV cycles, then GAP.
REQ-021 GAP: cs_n=1, sclk=0 for CLK_DIV cycles; done=1 on the last GAP cycle; then IDLE.
REQ-022 Accept-to-IDLE duration SHALL be exactly 35*CLK_DIV cycles; exactly 16 sclk rising edges per frame.
REQ-023 Back-to-back: din_valid held high SHALL be accepted on the first IDLE cycle after GAP, giving a period of 35*CLK_DIV+1 cycles.
REQ-024 enb deasserted in any state SHALL force IDLE on the next clock, with cs_n=1, sclk=0, mosi=0, no done pulse, and the partial frame discarded.
REQ-025 Half-period and bit counters SHALL wrap without overflow; CLK_DIV=1 SHALL give sclk = clk/2 during SHIFT.
REQ-026 din_valid while busy SHALL be ignored; the producer holds the value.

Reset
REQ-027 rst=1 at a clock edge SHALL force IDLE, cs_n=1, sclk=0, mosi=0, done=0, shift register=0 and counters=0; this applies mid-frame and has priority over enb.
REQ-028 During and after reset, din_ready SHALL be 0 until the first cycle with rst=0, enb=1 and state IDLE.

Verification
REQ-029 CLK_DIV=2, enb=1, single din=12'hABC pulse: mosi sampled on sclk rising edges = 16'h3ABC; cs_n low for 68 cycles; done pulses once 70 cycles after accept.
REQ-030 din=12'hFFF then 12'h000 with din_valid held high: two frames 16'h3FFF and 16'h3000, second accepted 1 cycle after the first done, cs_n high 3 cycles between frames.
REQ-031 enb dropped after the 5th sclk rising edge: next cycle cs_n=1, sclk=0, no done; re-enable and send 12'h50A: full frame 16'h350A.
REQ-032 rst asserted mid-SHIFT for 1 cycle: outputs at reset values next cycle; din_ready=1 the cycle after rst drops.
REQ-033 CLK_DIV=1, din=12'h001: sclk toggles every clk, frame 16'h3001, done 35 cycles after accept.
REQ-034 din changed every cycle during a frame: transmitted bits match the value latched at accept only.
